// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-rate divider, h/v scan counters and registered sync/blank decode.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
   parameter int TICK_DIV  = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
`ifdef VGA_FRAME_CNT_EN
   output logic       frame_start,
   output logic [7:0] frame_cnt
`else
   output logic       frame_start
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_VIS     = 10'(H_DISPLAY);
   localparam logic [9:0]    V_VIS     = 10'(V_DISPLAY);
   localparam logic [9:0]    H_SYNC_LO = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0]    H_SYNC_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]    V_SYNC_LO = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]    V_SYNC_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick_wrap;
   logic [9:0]    x_nxt, y_nxt;
   logic          p_tick_q, p_tick_d;
   logic [9:0]    pixel_x_q, pixel_x_d;
   logic [9:0]    pixel_y_q, pixel_y_d;
   logic          video_on_q, video_on_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          frame_start_q, frame_start_d;

   always_comb begin
      tick_wrap  = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;

      x_nxt = (pixel_x_q == H_LAST) ? '0 : pixel_x_q + 10'd1;
      y_nxt = pixel_y_q;
      if (pixel_x_q == H_LAST)
         y_nxt = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + 10'd1;

      p_tick_d      = tick_wrap;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      video_on_d    = video_on_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      frame_start_d = 1'b0;

      // Decode from the next counter values so sync/blank register with the counters.
      if (tick_wrap) begin
         pixel_x_d     = x_nxt;
         pixel_y_d     = y_nxt;
         video_on_d    = (x_nxt < H_VIS) && (y_nxt < V_VIS);
         hsync_d       = !((x_nxt >= H_SYNC_LO) && (x_nxt <= H_SYNC_HI));
         vsync_d       = !((y_nxt >= V_SYNC_LO) && (y_nxt <= V_SYNC_HI));
         frame_start_d = (x_nxt == '0) && (y_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q    <= '0;
         p_tick_q      <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         video_on_q    <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         p_tick_q      <= p_tick_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign p_tick      = p_tick_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) frame_cnt_q <= '0;
      else          frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
